// File: rtl/operand_fetch_if.sv
// Decode-to-execute operand fetch bus: decode offer, bank read ports, writeback, execute handoff.
interface operand_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  id_valid_i;
    logic                  id_ready_o;
    logic [ADDR_WIDTH-1:0] id_rs1_i;
    logic [ADDR_WIDTH-1:0] id_rs2_i;
    logic [ADDR_WIDTH-1:0] id_rd_i;
    logic                  id_rd_we_i;
    logic [ADDR_WIDTH-1:0] r0addr_o;
    logic [ADDR_WIDTH-1:0] r1addr_o;
    logic [DATA_WIDTH-1:0] r0data_i;
    logic [DATA_WIDTH-1:0] r1data_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  flush_i;
    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic [DATA_WIDTH-1:0] ex_rs1data_o;
    logic [DATA_WIDTH-1:0] ex_rs2data_o;
    logic [ADDR_WIDTH-1:0] ex_rd_o;
    logic                  ex_rd_we_o;

    // Environment side: decode, register bank, writeback and execute.
    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i,
        output r0data_i, r1data_i,
        output wb_we_i, wb_addr_i, wb_data_i,
        output flush_i, ex_ready_i,
        input  id_ready_o, r0addr_o, r1addr_o,
        input  ex_valid_o, ex_rs1data_o, ex_rs2data_o, ex_rd_o, ex_rd_we_o
    );

    // Operand fetch stage side.
    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i,
        input  r0data_i, r1data_i,
        input  wb_we_i, wb_addr_i, wb_data_i,
        input  flush_i, ex_ready_i,
        output id_ready_o, r0addr_o, r1addr_o,
        output ex_valid_o, ex_rs1data_o, ex_rs2data_o, ex_rd_o, ex_rd_we_o
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads two sources from the bank, stalls on busy registers,
// bypasses same-cycle writeback, and hands operands to execute via a one-entry stage.
module operand_fetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    operand_fetch_if.slave bus
);
    localparam int unsigned NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_next;
    logic [NREGS-1:0]      clr;
    logic [NREGS-1:0]      eff_busy;
    logic                  hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;

    // Bank read ports follow the decode sources directly.
    assign bus.r0addr_o = bus.id_rs1_i;
    assign bus.r1addr_o = bus.id_rs2_i;

    // Writeback this cycle retires the busy bit of its target (never x0).
    always_comb begin
        clr = '0;
        for (int i = 1; i < NREGS; i++) begin
            clr[i] = bus.wb_we_i && (bus.wb_addr_i == ADDR_WIDTH'(i));
        end
    end

    assign eff_busy = busy & ~clr;
    assign hazard   = eff_busy[bus.id_rs1_i] | eff_busy[bus.id_rs2_i]
                    | (bus.id_rd_we_i & eff_busy[bus.id_rd_i]);

    assign bus.id_ready_o = ~rst_i & ~bus.flush_i & ~hazard
                          & (~bus.ex_valid_o | bus.ex_ready_i);
    assign accept = bus.id_valid_i & bus.id_ready_o;

    // Operand select: x0 reads zero, then writeback bypass, then bank data.
    always_comb begin
        op1 = bus.r0data_i;
        op2 = bus.r1data_i;
        if (bus.id_rs1_i == '0) begin
            op1 = '0;
        end else if (bus.wb_we_i && (bus.wb_addr_i == bus.id_rs1_i)) begin
            op1 = bus.wb_data_i;
        end
        if (bus.id_rs2_i == '0) begin
            op2 = '0;
        end else if (bus.wb_we_i && (bus.wb_addr_i == bus.id_rs2_i)) begin
            op2 = bus.wb_data_i;
        end
    end

    // Scoreboard update: clear on writeback or flushed entry, set on accept (set wins).
    always_comb begin
        busy_next = busy & ~clr;
        if (bus.flush_i && bus.ex_valid_o && bus.ex_rd_we_o && (bus.ex_rd_o != '0)) begin
            busy_next[bus.ex_rd_o] = 1'b0;
        end
        if (accept && bus.id_rd_we_i && (bus.id_rd_i != '0)) begin
            busy_next[bus.id_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Execute handoff register: load on accept, drop on flush or consume, else hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.ex_valid_o   <= 1'b0;
            bus.ex_rs1data_o <= '0;
            bus.ex_rs2data_o <= '0;
            bus.ex_rd_o      <= '0;
            bus.ex_rd_we_o   <= 1'b0;
        end else if (bus.flush_i) begin
            bus.ex_valid_o   <= 1'b0;
        end else if (accept) begin
            bus.ex_valid_o   <= 1'b1;
            bus.ex_rs1data_o <= op1;
            bus.ex_rs2data_o <= op2;
            bus.ex_rd_o      <= bus.id_rd_i;
            bus.ex_rd_we_o   <= bus.id_rd_we_i;
        end else if (bus.ex_ready_i) begin
            bus.ex_valid_o   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed stimulus, expected handoffs queued and checked by a monitor.
module tb_operand_fetch;
    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] bank [32];
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    operand_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Register bank model: async read, write at the edge, x0 not forced.
    assign bus.r0data_i = bank[bus.r0addr_o];
    assign bus.r1data_i = bank[bus.r1addr_o];
    always @(posedge clk_i) begin
        if (bus.wb_we_i) bank[bus.wb_addr_i] <= bus.wb_data_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake with execute must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i && bus.ex_valid_o && bus.ex_ready_i && !bus.flush_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ex: got rs1=0x%0h with no expected entry at %0t",
                         bus.ex_rs1data_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ex_rs1data", bus.ex_rs1data_o, e.d1);
                chk("ex_rs2data", bus.ex_rs2data_o, e.d2);
                chk("ex_rd", 32'(bus.ex_rd_o), 32'(e.rd));
                chk("ex_rd_we", 32'(bus.ex_rd_we_o), 32'(e.we));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] rd, input logic we);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.rd = rd; e.we = we;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we);
        bus.id_valid_i = 1'b1;
        bus.id_rs1_i   = rs1;
        bus.id_rs2_i   = rs2;
        bus.id_rd_i    = rd;
        bus.id_rd_we_i = we;
    endtask

    // Offer one instruction, wait (bounded) for acceptance, queue the expected operands.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [31:0] e1, input logic [31:0] e2);
        int n;
        n = 0;
        set_id(rs1, rs2, rd, we);
        #1;
        while (!bus.id_ready_o && n < 20) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        if (!bus.id_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: id_ready_o stayed 0 for rs1=%0d rs2=%0d", rs1, rs2);
        end else begin
            push_exp(e1, e2, rd, we);
        end
        cyc();
        bus.id_valid_i = 1'b0;
    endtask

    task automatic wb_set(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i   = we;
        bus.wb_addr_i = a;
        bus.wb_data_i = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        rst_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        wb_set(1'b0, 5'd0, 32'h0);
        set_id(5'd3, 5'd4, 5'd1, 1'b1);

        // Reset state.
        cyc(); cyc();
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid_o), 32'h0);
        chk("rst_rs1data", bus.ex_rs1data_o, 32'h0);
        chk("rst_rs2data", bus.ex_rs2data_o, 32'h0);
        chk("rst_rd", 32'(bus.ex_rd_o), 32'h0);
        chk("rst_rd_we", 32'(bus.ex_rd_we_o), 32'h0);
        chk("rst_id_ready", 32'(bus.id_ready_o), 32'h0);
        bus.id_valid_i = 1'b0;
        cyc();
        rst_i = 1'b0;

        // Basic read, one-cycle latency.
        bank[3] = 32'h11;
        bank[4] = 32'h22;
        issue(5'd3, 5'd4, 5'd0, 1'b0, 32'h11, 32'h22);
        chk("latency_ex_valid", 32'(bus.ex_valid_o), 32'h1);
        chk("addr_r0", 32'(bus.r0addr_o), 32'd3);

        // x0 forced to zero even though the bank returns garbage.
        bank[0] = 32'hDEADBEEF;
        issue(5'd0, 5'd4, 5'd0, 1'b0, 32'h0, 32'h22);
        // Writeback to x0 alongside an x0 write: no bypass, no busy.
        wb_set(1'b1, 5'd0, 32'h55);
        issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
        wb_set(1'b0, 5'd0, 32'h0);
        set_id(5'd0, 5'd3, 5'd0, 1'b1);
        #1;
        chk("x0_not_busy_ready", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'h0, 32'h11, 5'd0, 1'b1);
        cyc();
        bus.id_valid_i = 1'b0;

        // RAW on x5: stall until writeback, then bypass.
        bank[1] = 32'h101;
        bank[2] = 32'h202;
        bank[5] = 32'h5555;
        issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h101, 32'h202);
        set_id(5'd5, 5'd3, 5'd6, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("raw_stall_ready", 32'(bus.id_ready_o), 32'h0);
            cyc();
        end
        wb_set(1'b1, 5'd5, 32'hCAFE);
        #1;
        chk("raw_wb_ready", 32'(bus.id_ready_o), 32'h1);
        chk("raw_bank_old", bus.r0data_i, 32'h5555);
        push_exp(32'hCAFE, 32'h11, 5'd6, 1'b1);
        cyc();
        bus.id_valid_i = 1'b0;
        wb_set(1'b1, 5'd6, 32'h666);
        cyc();
        wb_set(1'b0, 5'd0, 32'h0);

        // Backpressure: entry held stable, then back-to-back transfer.
        bus.ex_ready_i = 1'b0;
        issue(5'd3, 5'd4, 5'd8, 1'b0, 32'h11, 32'h22);
        set_id(5'd4, 5'd3, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ex_valid", 32'(bus.ex_valid_o), 32'h1);
            chk("bp_rs1data", bus.ex_rs1data_o, 32'h11);
            chk("bp_rs2data", bus.ex_rs2data_o, 32'h22);
            chk("bp_rd", 32'(bus.ex_rd_o), 32'd8);
            chk("bp_rd_we", 32'(bus.ex_rd_we_o), 32'h0);
            chk("bp_id_ready", 32'(bus.id_ready_o), 32'h0);
            cyc();
        end
        bus.ex_ready_i = 1'b1;
        #1;
        chk("b2b_id_ready", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'h22, 32'h11, 5'd0, 1'b0);
        cyc();
        bus.id_valid_i = 1'b0;
        chk("b2b_no_bubble", 32'(bus.ex_valid_o), 32'h1);
        cyc();

        // WAW on x7: second writer stalls, busy stays set after the first writeback.
        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
        set_id(5'd0, 5'd0, 5'd7, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("waw_stall_ready", 32'(bus.id_ready_o), 32'h0);
            cyc();
        end
        wb_set(1'b1, 5'd7, 32'h77);
        #1;
        chk("waw_wb_ready", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'h0, 32'h0, 5'd7, 1'b1);
        cyc();
        wb_set(1'b0, 5'd0, 32'h0);
        set_id(5'd7, 5'd0, 5'd0, 1'b0);
        #1;
        chk("waw_busy_kept", 32'(bus.id_ready_o), 32'h0);
        cyc();
        wb_set(1'b1, 5'd7, 32'h99);
        #1;
        chk("waw_second_wb_ready", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'h99, 32'h0, 5'd0, 1'b0);
        cyc();
        bus.id_valid_i = 1'b0;
        wb_set(1'b0, 5'd0, 32'h0);
        cyc();

        // Flush a held x9 writer; its busy bit is released.
        bank[9] = 32'h909;
        bus.ex_ready_i = 1'b0;
        issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
        bus.flush_i = 1'b1;
        set_id(5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        chk("flush_id_ready", 32'(bus.id_ready_o), 32'h0);
        cyc();
        bus.flush_i = 1'b0;
        chk("flush_ex_valid", 32'(bus.ex_valid_o), 32'h0);
        chk("flush_q_size", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        #1;
        chk("flush_reader_ready", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'h909, 32'h0, 5'd0, 1'b0);
        cyc();
        bus.id_valid_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        cyc();

        // Reset mid-handshake drops the entry and clears the scoreboard.
        bank[10] = 32'hA0A;
        bus.ex_ready_i = 1'b0;
        issue(5'd0, 5'd0, 5'd10, 1'b1, 32'h0, 32'h0);
        rst_i = 1'b1;
        cyc();
        chk("midrst_ex_valid", 32'(bus.ex_valid_o), 32'h0);
        chk("midrst_id_ready", 32'(bus.id_ready_o), 32'h0);
        rst_i = 1'b0;
        exp_q.delete();
        set_id(5'd10, 5'd0, 5'd0, 1'b0);
        #1;
        chk("midrst_busy_cleared", 32'(bus.id_ready_o), 32'h1);
        push_exp(32'hA0A, 32'h0, 5'd0, 1'b0);
        cyc();
        bus.id_valid_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        cyc(); cyc();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
